// File: rtl/traductor_bcd_binario_if.sv
// traductor_bcd_binario_if: request/result bundle of the BCD-to-binary converter.
// master drives start/bcd_in; slave returns busy, done, bin_out and err.
interface traductor_bcd_binario_if #(
    parameter int DIGITS = 2,
    parameter int BIN_W  = 7
);
    logic                  start;
    logic [4*DIGITS-1:0]   bcd_in;
    logic                  busy;
    logic                  done;
    logic [BIN_W-1:0]      bin_out;
    logic                  err;

    modport master (
        output start,
        output bcd_in,
        input  busy,
        input  done,
        input  bin_out,
        input  err
    );

    modport slave (
        input  start,
        input  bcd_in,
        output busy,
        output done,
        output bin_out,
        output err
    );
endinterface

// File: rtl/traductor_bcd_binario.sv
// traductor_bcd_binario: sequential BCD-to-binary converter (reverse double-dabble).
// Ports: clk, rst (sync, active-high); bus.slave = start, bcd_in -> busy, done, bin_out, err.
module traductor_bcd_binario #(
    parameter int DIGITS = 2,
    parameter int BIN_W  = 7
) (
    input  logic                     clk,
    input  logic                     rst,
    traductor_bcd_binario_if.slave   bus
);
    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(BIN_W) + 1;
    localparam int SH_W  = BCD_W + BIN_W;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(BIN_W - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t             state;
    logic [BCD_W-1:0]   bcd_sh;
    logic [BIN_W-1:0]   bin_sh;
    logic [CNT_W-1:0]   cnt;

    logic [SH_W-1:0]    sh;
    logic [BCD_W-1:0]   bcd_adj;
    logic               bad;

    // One reverse double-dabble step: shift the whole register right,
    // then pull every digit that received a carried-in 8 back by 3.
    always_comb begin
        sh      = {bcd_sh, bin_sh} >> 1;
        bcd_adj = sh[SH_W-1:BIN_W];
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_adj[4*i +: 4] >= 4'd8) begin
                bcd_adj[4*i +: 4] = bcd_adj[4*i +: 4] - 4'd3;
            end
        end
    end

    always_comb begin
        bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (bus.bcd_in[4*i +: 4] > 4'd9) begin
                bad = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            bcd_sh      <= '0;
            bin_sh      <= '0;
            cnt         <= '0;
            bus.busy    <= 1'b0;
            bus.done    <= 1'b0;
            bus.bin_out <= '0;
            bus.err     <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        bus.busy <= 1'b1;
                        if (bad) begin
                            bus.bin_out <= '0;
                            bus.err     <= 1'b1;
                            bus.done    <= 1'b1;
                            state       <= DONE;
                        end else begin
                            bcd_sh <= bus.bcd_in;
                            bin_sh <= '0;
                            cnt    <= '0;
                            state  <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    bcd_sh <= bcd_adj;
                    bin_sh <= sh[BIN_W-1:0];
                    cnt    <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        bus.bin_out <= sh[BIN_W-1:0];
                        bus.err     <= 1'b0;
                        bus.done    <= 1'b1;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    bus.done <= 1'b0;
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_traductor_bcd_binario.sv
// tb_traductor_bcd_binario: randomized self-checking bench for the BCD-to-binary converter.
// Expected results come from decimal arithmetic on the BCD digits.
module tb_traductor_bcd_binario;
    localparam int DIGITS = 2;
    localparam int BIN_W  = 7;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_fail;

    traductor_bcd_binario_if #(.DIGITS(DIGITS), .BIN_W(BIN_W)) bus ();

    traductor_bcd_binario #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: decimal value of the digits, or error on any digit > 9.
    function automatic void model(input logic [7:0] b, output int v, output logic e);
        int t;
        int u;
        t = int'(b[7:4]);
        u = int'(b[3:0]);
        e = (t > 9) || (u > 9);
        v = e ? 0 : 10 * t + u;
    endfunction

    // Drives one request and observes it; lat is the sample index (0 = right
    // after the accepting edge) of the first done, or -1 if none appeared.
    task automatic convert(input logic [7:0] b, output int lat, output int nbusy,
                           output int ndone, output int bin, output logic e);
        lat   = -1;
        nbusy = 0;
        ndone = 0;
        bin   = 0;
        e     = 1'b0;
        bus.bcd_in = b;
        bus.start  = 1'b1;
        @(posedge clk);
        for (int k = 0; k < 3 * BIN_W + 6; k++) begin
            @(negedge clk);
            bus.start = 1'b0;
            if (bus.busy) nbusy++;
            if (bus.done) begin
                ndone++;
                if (lat < 0) begin
                    lat = k;
                    bin = int'(bus.bin_out);
                    e   = bus.err;
                end
            end
            if (lat >= 0 && !bus.busy) break;
        end
    endtask

    task automatic test_reset();
        rst        = 1'b1;
        bus.start  = 1'b1;
        bus.bcd_in = 8'h42;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if ({bus.busy, bus.done, bus.err, bus.bin_out} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got busy=%b done=%b err=%b bin=%0d want all 0",
                     bus.busy, bus.done, bus.err, bus.bin_out);
        end
        rst       = 1'b0;
        bus.start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle: got busy=%b want 0", bus.busy);
        end
    endtask

    task automatic test_max();
        int lat, nb, nd, bin;
        logic e;
        convert(8'h99, lat, nb, nd, bin, e);
        n_cmp++;
        if (lat !== BIN_W || nb !== BIN_W + 1 || nd !== 1) begin
            n_fail++;
            $display("FAIL max_timing: got lat=%0d busy=%0d done=%0d want %0d/%0d/1",
                     lat, nb, nd, BIN_W, BIN_W + 1);
        end
        n_cmp++;
        if (bin !== 99 || e !== 1'b0) begin
            n_fail++;
            $display("FAIL max_value: got bin=%0d err=%b want 99/0", bin, e);
        end
    endtask

    task automatic test_small();
        logic [7:0] v[2];
        int lat, nb, nd, bin, exp;
        logic e, ee;
        v[0] = 8'h00;
        v[1] = 8'h31;
        foreach (v[i]) begin
            convert(v[i], lat, nb, nd, bin, e);
            model(v[i], exp, ee);
            n_cmp++;
            if (lat !== BIN_W || bin !== exp || e !== ee) begin
                n_fail++;
                $display("FAIL small_%h: got lat=%0d bin=%0d err=%b want %0d/%0d/%b",
                         v[i], lat, bin, e, BIN_W, exp, ee);
            end
        end
    endtask

    task automatic test_sweep();
        int lat, nb, nd, bin, exp;
        logic e, ee;
        logic [7:0] b;
        for (int t = 0; t < 10; t++) begin
            for (int u = 0; u < 10; u++) begin
                b = {4'(t), 4'(u)};
                convert(b, lat, nb, nd, bin, e);
                model(b, exp, ee);
                n_cmp++;
                if (lat !== BIN_W || nd !== 1 || bin !== exp || e !== ee) begin
                    n_fail++;
                    $display("FAIL sweep_%h: got lat=%0d nd=%0d bin=%0d err=%b want %0d/1/%0d/%b",
                             b, lat, nd, bin, e, BIN_W, exp, ee);
                end
            end
        end
    endtask

    task automatic test_invalid();
        int lat, nb, nd, bin;
        logic e;
        convert(8'h1A, lat, nb, nd, bin, e);
        n_cmp++;
        if (lat !== 0 || nb !== 1 || nd !== 1 || bin !== 0 || e !== 1'b1) begin
            n_fail++;
            $display("FAIL invalid_1A: got lat=%0d busy=%0d nd=%0d bin=%0d err=%b want 0/1/1/0/1",
                     lat, nb, nd, bin, e);
        end
        convert(8'h42, lat, nb, nd, bin, e);
        n_cmp++;
        if (lat !== BIN_W || bin !== 42 || e !== 1'b0) begin
            n_fail++;
            $display("FAIL after_invalid: got lat=%0d bin=%0d err=%b want %0d/42/0",
                     lat, bin, e, BIN_W);
        end
    endtask

    task automatic test_random();
        int lat, nb, nd, bin, exp, explat, expnb;
        logic e, ee;
        logic [7:0] b;
        for (int n = 0; n < 40; n++) begin
            b = 8'($urandom_range(0, 255));
            if (n % 3 != 0) b = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
            model(b, exp, ee);
            explat = ee ? 0 : BIN_W;
            expnb  = explat + 1;
            convert(b, lat, nb, nd, bin, e);
            n_cmp++;
            if (lat !== explat || nb !== expnb || nd !== 1 || bin !== exp || e !== ee) begin
                n_fail++;
                $display("FAIL random_%h: got lat=%0d busy=%0d nd=%0d bin=%0d err=%b want %0d/%0d/1/%0d/%b",
                         b, lat, nb, nd, bin, e, explat, expnb, exp, ee);
            end
        end
    endtask

    // start held high across a completion: the second conversion must begin
    // at the first IDLE cycle after done and see the updated bcd_in.
    task automatic test_back_to_back();
        int lat1, lat2, bin1, bin2;
        lat1 = -1;
        lat2 = -1;
        bin1 = 0;
        bin2 = 0;
        bus.bcd_in = 8'h23;
        bus.start  = 1'b1;
        @(posedge clk);
        for (int k = 0; k < 4 * BIN_W + 8; k++) begin
            @(negedge clk);
            if (k == 3) bus.bcd_in = 8'h55;
            if (bus.done) begin
                if (lat1 < 0) begin
                    lat1 = k;
                    bin1 = int'(bus.bin_out);
                end else if (lat2 < 0) begin
                    lat2 = k;
                    bin2 = int'(bus.bin_out);
                    bus.start = 1'b0;
                end
            end
            if (lat2 >= 0 && !bus.busy) break;
        end
        bus.start = 1'b0;
        n_cmp++;
        if (lat1 !== BIN_W || bin1 !== 23) begin
            n_fail++;
            $display("FAIL held_first: got lat=%0d bin=%0d want %0d/23", lat1, bin1, BIN_W);
        end
        n_cmp++;
        if (lat2 !== 2 * BIN_W + 2 || bin2 !== 55) begin
            n_fail++;
            $display("FAIL held_second: got lat=%0d bin=%0d want %0d/55",
                     lat2, bin2, 2 * BIN_W + 2);
        end
        repeat (2) @(negedge clk);
        n_cmp++;
        if (bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL held_no_third: got busy=%b want 0", bus.busy);
        end
    endtask

    task automatic test_reset_abort();
        int lat, nb, nd, bin, nd_abort;
        logic e;
        nd_abort = 0;
        bus.bcd_in = 8'h77;
        bus.start  = 1'b1;
        @(posedge clk);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            bus.start = 1'b0;
            if (bus.done) nd_abort++;
        end
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (nd_abort !== 0 || {bus.busy, bus.done, bus.err, bus.bin_out} !== '0) begin
            n_fail++;
            $display("FAIL abort_outputs: got nd=%0d busy=%b done=%b err=%b bin=%0d want all 0",
                     nd_abort, bus.busy, bus.done, bus.err, bus.bin_out);
        end
        rst = 1'b0;
        repeat (BIN_W + 2) begin
            @(negedge clk);
            if (bus.done) nd_abort++;
        end
        n_cmp++;
        if (nd_abort !== 0) begin
            n_fail++;
            $display("FAIL abort_no_done: got %0d done pulses want 0", nd_abort);
        end
        convert(8'h77, lat, nb, nd, bin, e);
        n_cmp++;
        if (lat !== BIN_W || bin !== 77 || e !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_retry: got lat=%0d bin=%0d err=%b want %0d/77/0",
                     lat, bin, e, BIN_W);
        end
    endtask

    initial begin
        n_cmp      = 0;
        n_fail     = 0;
        rst        = 1'b1;
        bus.start  = 1'b0;
        bus.bcd_in = '0;
        @(negedge clk);
        test_reset();
        test_max();
        test_small();
        test_sweep();
        test_invalid();
        test_random();
        test_back_to_back();
        test_reset_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
